// File: rtl/uart_led_cmd_parser.sv
// UART LED command parser: assembles HEADER/CMD/DATA/CHK frames from uart_rx,
// executes them on an LED register and returns one response byte via uart_tx.
module uart_led_cmd_parser #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter logic [7:0] LED_INIT       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic       tx_req,
    output logic [7:0] tx_byte,
    output logic [7:0] led,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_SET    = 8'h01;
    localparam logic [7:0] CMD_TOGGLE = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_DATA,
        GET_CHK,
        RESP,
        RESP_WAIT
    } state_t;

    state_t        state, state_n;
    logic [7:0]    cmd, cmd_n;
    logic [7:0]    data, data_n;
    logic [7:0]    led_n, tx_byte_n, err_cnt_n;
    logic          tx_req_n, ok_n, err_n, bump;
    logic [CW-1:0] cnt, cnt_n;
    logic          known;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd       <= 8'h00;
            data      <= 8'h00;
            led       <= LED_INIT;
            tx_req    <= 1'b0;
            tx_byte   <= 8'h00;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= 8'h00;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            cmd       <= cmd_n;
            data      <= data_n;
            led       <= led_n;
            tx_req    <= tx_req_n;
            tx_byte   <= tx_byte_n;
            frame_ok  <= ok_n;
            frame_err <= err_n;
            err_cnt   <= err_cnt_n;
            cnt       <= cnt_n;
        end
    end

    assign known = (cmd == CMD_SET) || (cmd == CMD_TOGGLE) || (cmd == CMD_READ);

    always_comb begin
        state_n   = state;
        cmd_n     = cmd;
        data_n    = data;
        led_n     = led;
        tx_req_n  = tx_req;
        tx_byte_n = tx_byte;
        ok_n      = 1'b0;
        err_n     = 1'b0;
        bump      = 1'b0;
        cnt_n     = '0;
        err_cnt_n = err_cnt;

        unique case (state)
            IDLE: begin
                if (rx_valid && rx_byte == HEADER)
                    state_n = GET_CMD;
            end
            GET_CMD, GET_DATA, GET_CHK: begin
                if (rx_valid) begin
                    if (state == GET_CMD) begin
                        cmd_n   = rx_byte;
                        state_n = GET_DATA;
                    end else if (state == GET_DATA) begin
                        data_n  = rx_byte;
                        state_n = GET_CHK;
                    end else begin
                        if (known && rx_byte == (cmd ^ data)) begin
                            ok_n = 1'b1;
                            if (cmd == CMD_SET)
                                led_n = data;
                            else if (cmd == CMD_TOGGLE)
                                led_n = led ^ data;
                            tx_byte_n = (cmd == CMD_READ) ? led : ACK;
                        end else begin
                            err_n     = 1'b1;
                            bump      = 1'b1;
                            tx_byte_n = NAK;
                        end
                        tx_req_n = 1'b1;
                        state_n  = RESP;
                    end
                end else if (cnt == TMO_LAST) begin
                    // Frame abandoned: error, but no response byte.
                    err_n   = 1'b1;
                    bump    = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP: begin
                if (tx_busy) begin
                    tx_req_n = 1'b0;
                    state_n  = RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                if (!tx_busy)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (bump && err_cnt != 8'hFF)
            err_cnt_n = err_cnt + 8'h01;
    end

endmodule

// File: tb/tb_uart_led_cmd_parser.sv
// Directed testbench for uart_led_cmd_parser (short timeout for speed).
module tb_uart_led_cmd_parser;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_busy;
    logic       tx_req;
    logic [7:0] tx_byte;
    logic [7:0] led;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_cnt;

    int tests = 0;
    int fails = 0;

    uart_led_cmd_parser #(
        .HEADER(8'hA5),
        .LED_INIT(8'h00),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .tx_busy(tx_busy),
        .tx_req(tx_req),
        .tx_byte(tx_byte),
        .led(led),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // All tasks start and end at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(d);
        send_byte(k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic finish_resp();
        tx_busy = 1'b1;
        @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        tests++; if (led !== 8'h00) begin fails++; $display("FAIL reset_led got %h exp 00", led); end
        tests++; if (tx_req !== 1'b0) begin fails++; $display("FAIL reset_tx_req got %b exp 0", tx_req); end
        tests++; if (tx_byte !== 8'h00) begin fails++; $display("FAIL reset_tx_byte got %h exp 00", tx_byte); end
        tests++; if (err_cnt !== 8'h00) begin fails++; $display("FAIL reset_err_cnt got %h exp 00", err_cnt); end
        tests++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin
            fails++; $display("FAIL reset_pulses got ok=%b err=%b exp 0 0", frame_ok, frame_err);
        end
    endtask

    task automatic test_set();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h3C);
        tests++; if (led !== 8'h00 || tx_req !== 1'b0) begin
            fails++; $display("FAIL set_early got led=%h req=%b exp 00 0", led, tx_req);
        end
        send_byte(8'h3D);
        tests++; if (led !== 8'h3C) begin fails++; $display("FAIL set_led got %h exp 3c", led); end
        tests++; if (frame_ok !== 1'b1 || frame_err !== 1'b0) begin
            fails++; $display("FAIL set_pulse got ok=%b err=%b exp 1 0", frame_ok, frame_err);
        end
        tests++; if (tx_req !== 1'b1 || tx_byte !== 8'h06) begin
            fails++; $display("FAIL set_resp got req=%b byte=%h exp 1 06", tx_req, tx_byte);
        end
        idle(3);
        tests++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL set_ok_one_cycle got %b exp 0", frame_ok); end
        tests++; if (tx_req !== 1'b1 || tx_byte !== 8'h06) begin
            fails++; $display("FAIL set_hold got req=%b byte=%h exp 1 06", tx_req, tx_byte);
        end
        tx_busy = 1'b1;
        @(negedge clk);
        tests++; if (tx_req !== 1'b0) begin fails++; $display("FAIL set_req_drop got %b exp 0", tx_req); end
        tx_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_toggle_read();
        send_frame(8'h02, 8'hFF, 8'hFD);
        tests++; if (led !== 8'hC3 || tx_byte !== 8'h06 || frame_ok !== 1'b1) begin
            fails++; $display("FAIL toggle got led=%h byte=%h ok=%b exp c3 06 1", led, tx_byte, frame_ok);
        end
        finish_resp();
        send_frame(8'h03, 8'h00, 8'h03);
        tests++; if (led !== 8'hC3 || tx_byte !== 8'hC3 || tx_req !== 1'b1) begin
            fails++; $display("FAIL read got led=%h byte=%h req=%b exp c3 c3 1", led, tx_byte, tx_req);
        end
        finish_resp();
    endtask

    task automatic test_errors();
        send_frame(8'h01, 8'h55, 8'h00);
        tests++; if (led !== 8'hC3 || frame_err !== 1'b1 || frame_ok !== 1'b0) begin
            fails++; $display("FAIL bad_chk got led=%h err=%b ok=%b exp c3 1 0", led, frame_err, frame_ok);
        end
        tests++; if (err_cnt !== 8'd1 || tx_byte !== 8'h15 || tx_req !== 1'b1) begin
            fails++; $display("FAIL bad_chk_resp got cnt=%h byte=%h req=%b exp 01 15 1", err_cnt, tx_byte, tx_req);
        end
        finish_resp();
        send_frame(8'h07, 8'h00, 8'h07);
        tests++; if (err_cnt !== 8'd2 || tx_byte !== 8'h15 || frame_err !== 1'b1 || led !== 8'hC3) begin
            fails++; $display("FAIL bad_cmd got cnt=%h byte=%h err=%b led=%h exp 02 15 1 c3",
                err_cnt, tx_byte, frame_err, led);
        end
        finish_resp();
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(T - 1);
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL tmo_early got %b exp 0", frame_err); end
        idle(1);
        tests++; if (frame_err !== 1'b1 || err_cnt !== 8'd3 || tx_req !== 1'b0) begin
            fails++; $display("FAIL tmo got err=%b cnt=%h req=%b exp 1 03 0", frame_err, err_cnt, tx_req);
        end
        idle(1);
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL tmo_one_cycle got %b exp 0", frame_err); end
        // Each byte lands exactly on the expiry edge and must be accepted.
        send_byte(8'hA5);
        idle(T - 1);
        send_byte(8'h01);
        idle(T - 1);
        send_byte(8'h0F);
        idle(T - 1);
        send_byte(8'h0E);
        tests++; if (led !== 8'h0F || frame_ok !== 1'b1 || err_cnt !== 8'd3) begin
            fails++; $display("FAIL tmo_edge got led=%h ok=%b cnt=%h exp 0f 1 03", led, frame_ok, err_cnt);
        end
        finish_resp();
    endtask

    task automatic test_junk();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        tests++; if (err_cnt !== 8'd3 || frame_err !== 1'b0 || tx_req !== 1'b0) begin
            fails++; $display("FAIL junk got cnt=%h err=%b req=%b exp 03 0 0", err_cnt, frame_err, tx_req);
        end
        send_frame(8'h01, 8'hAA, 8'hAB);
        tests++; if (led !== 8'hAA || frame_ok !== 1'b1) begin
            fails++; $display("FAIL junk_frame got led=%h ok=%b exp aa 1", led, frame_ok);
        end
        tx_busy = 1'b1;
        send_frame(8'h01, 8'h55, 8'h54);
        tests++; if (led !== 8'hAA || frame_ok !== 1'b0 || tx_req !== 1'b0) begin
            fails++; $display("FAIL busy_ignore got led=%h ok=%b req=%b exp aa 0 0", led, frame_ok, tx_req);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        send_frame(8'h02, 8'h0F, 8'h0D);
        tests++; if (led !== 8'hA5 || frame_ok !== 1'b1 || tx_byte !== 8'h06) begin
            fails++; $display("FAIL after_busy got led=%h ok=%b byte=%h exp a5 1 06", led, frame_ok, tx_byte);
        end
        finish_resp();
    endtask

    task automatic test_reset_resp();
        send_frame(8'h01, 8'h12, 8'h13);
        tests++; if (tx_req !== 1'b1 || led !== 8'h12) begin
            fails++; $display("FAIL pre_rst got req=%b led=%h exp 1 12", tx_req, led);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (tx_req !== 1'b0 || led !== 8'h00 || err_cnt !== 8'h00 || tx_byte !== 8'h00) begin
            fails++; $display("FAIL rst_resp got req=%b led=%h cnt=%h byte=%h exp 0 00 00 00",
                tx_req, led, err_cnt, tx_byte);
        end
        send_frame(8'h01, 8'h5A, 8'h5B);
        tests++; if (led !== 8'h5A || frame_ok !== 1'b1) begin
            fails++; $display("FAIL rst_idle got led=%h ok=%b exp 5a 1", led, frame_ok);
        end
        finish_resp();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 255; i++) begin
            send_frame(8'h01, 8'h00, 8'h00);
            finish_resp();
        end
        tests++; if (err_cnt !== 8'hFF) begin fails++; $display("FAIL sat_255 got %h exp ff", err_cnt); end
        send_frame(8'h01, 8'h00, 8'h00);
        tests++; if (err_cnt !== 8'hFF || frame_err !== 1'b1 || led !== 8'h5A) begin
            fails++; $display("FAIL sat_256 got cnt=%h err=%b led=%h exp ff 1 5a", err_cnt, frame_err, led);
        end
        finish_resp();
    endtask

    initial begin
        rst      = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        @(negedge clk);
        test_reset();
        test_set();
        test_toggle_read();
        test_errors();
        test_timeout();
        test_junk();
        test_reset_resp();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
